afe_iq_port: RTL and testbench

- Parametrised successor to the AFE RX/TX data interface.
- RX: de-interleaves the half-width I/Q bus from the converter into full I/Q pair words for the RX FIFO, tagged with a time-multiplexed channel index.
- TX: reads pair words from a show-ahead TX FIFO and interleaves them onto the half-width converter bus.
- Adds a single-clock synchronous design, digital loopback, overflow/underflow statistics, alignment-error detection and an enable gate. Sits between the AFE pins and the RX/TX FIFOs.

---
 rtl/afe_pkg.sv | 13 +
 rtl/afe_sat_counter.sv | 27 ++
 rtl/afe_iq_port.sv | 164 ++++++++++++++++
 tb/tb_afe_iq_port.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_pkg.sv
// Shared constants and helpers for the AFE I/Q port.
package afe_pkg;

  // Converter phase encoding on rx_sel / tx_sel
  localparam logic SEL_I = 1'b1;
  localparam logic SEL_Q = 1'b0;

  // Channel-index width: at least one bit, even for a single channel
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/afe_sat_counter.sv
// Saturating statistics counter with synchronous clear.
module afe_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  // Count up until all-ones; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/afe_iq_port.sv
// AFE converter data port: RX de-interleave to pair words, TX interleave
// from a show-ahead FIFO, digital loopback and error statistics.
module afe_iq_port
  import afe_pkg::*;
#(
  parameter  int unsigned SAMPLE_WIDTH = 12,
  parameter  int unsigned NUM_CH       = 1,
  parameter  int unsigned CNT_WIDTH    = 16,
  localparam int unsigned CH_W         = ch_width(NUM_CH)
) (
  input  logic                      sclk_2x,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      loopback,
  input  logic                      clr_stats,
  input  logic                      rx_sel,
  input  logic [SAMPLE_WIDTH-1:0]   rx_d,
  input  logic                      rx_fifo_full,
  output logic [2*SAMPLE_WIDTH-1:0] rx_fifo_data,
  output logic [CH_W-1:0]           rx_fifo_ch,
  output logic                      rx_fifo_wr,
  input  logic                      tx_fifo_empty,
  input  logic [2*SAMPLE_WIDTH-1:0] tx_fifo_data,
  output logic                      tx_fifo_rd,
  output logic                      tx_sel,
  output logic [SAMPLE_WIDTH-1:0]   tx_d,
  output logic [CNT_WIDTH-1:0]      rx_ovf_cnt,
  output logic [CNT_WIDTH-1:0]      tx_unf_cnt,
  output logic                      rx_align_err
);

  localparam int unsigned     SW      = SAMPLE_WIDTH;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  // TX state
  logic              r_phase;
  logic              r_hold_valid;
  logic [2*SW-1:0]   r_hold;

  // RX state
  logic              r_pend;
  logic [SW-1:0]     r_i;
  logic [CH_W-1:0]   r_ch;
  logic [2*SW-1:0]   r_rx_data;
  logic [CH_W-1:0]   r_rx_ch;
  logic              r_rx_wr;
  logic              r_align_err;

  logic              w_tx_en;
  logic              w_fetch;
  logic              w_tx_unf;
  logic              w_src_sel;
  logic [SW-1:0]     w_src_d;
  logic              w_pair_done;
  logic              w_rx_drop;
  logic              w_align_err;
  logic [CH_W-1:0]   w_ch_next;

  // TX outputs are gated so the converter sees zeros while held in reset or disabled
  always_comb begin
    w_tx_en    = enable & ~reset;
    w_fetch    = w_tx_en & (r_phase == SEL_Q);
    tx_sel     = w_tx_en ? r_phase : SEL_Q;
    tx_fifo_rd = w_fetch & ~tx_fifo_empty;
    w_tx_unf   = w_fetch & tx_fifo_empty;
    tx_d       = '0;
    if (w_tx_en && r_hold_valid) begin
      tx_d = (r_phase == SEL_I) ? r_hold[SW-1:0] : r_hold[2*SW-1:SW];
    end
  end

  // TX phase toggle and hold register load on fetch slots
  always_ff @(posedge sclk_2x) begin
    if (reset) begin
      r_phase      <= SEL_Q;
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
    end else if (!enable) begin
      r_phase      <= SEL_Q;
      r_hold_valid <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
      if (r_phase == SEL_Q) begin
        if (!tx_fifo_empty) begin
          r_hold       <= tx_fifo_data;
          r_hold_valid <= 1'b1;
        end else begin
          r_hold_valid <= 1'b0;
        end
      end
    end
  end

  // RX source select and pair/error decode
  always_comb begin
    w_src_sel   = loopback ? tx_sel : rx_sel;
    w_src_d     = loopback ? tx_d   : rx_d;
    w_pair_done = enable & (w_src_sel == SEL_Q) & r_pend;
    w_rx_drop   = w_pair_done & rx_fifo_full;
    w_align_err = enable & (((w_src_sel == SEL_Q) & ~r_pend) |
                            ((w_src_sel == SEL_I) &  r_pend));
    w_ch_next   = (r_ch == CH_LAST) ? '0 : r_ch + CH_W'(1);
  end

  // RX capture: I waits in r_i until its Q completes the pair
  always_ff @(posedge sclk_2x) begin
    if (reset) begin
      r_pend    <= 1'b0;
      r_i       <= '0;
      r_ch      <= '0;
      r_rx_data <= '0;
      r_rx_ch   <= '0;
      r_rx_wr   <= 1'b0;
    end else begin
      r_rx_wr <= 1'b0;
      if (!enable) begin
        r_pend <= 1'b0;
        r_ch   <= '0;
      end else if (w_src_sel == SEL_I) begin
        r_i    <= w_src_d;
        r_pend <= 1'b1;
      end else if (r_pend) begin
        r_pend    <= 1'b0;
        r_rx_data <= {w_src_d, r_i};
        r_rx_ch   <= r_ch;
        r_rx_wr   <= ~rx_fifo_full;
        r_ch      <= w_ch_next;
      end
    end
  end

  // Sticky alignment error, cleared with the statistics
  always_ff @(posedge sclk_2x) begin
    if (reset) begin
      r_align_err <= 1'b0;
    end else if (clr_stats) begin
      r_align_err <= 1'b0;
    end else if (w_align_err) begin
      r_align_err <= 1'b1;
    end
  end

  afe_sat_counter #(.WIDTH(CNT_WIDTH)) u_ovf_cnt (
    .clk   (sclk_2x),
    .reset (reset),
    .inc   (w_rx_drop),
    .clr   (clr_stats),
    .cnt   (rx_ovf_cnt)
  );

  afe_sat_counter #(.WIDTH(CNT_WIDTH)) u_unf_cnt (
    .clk   (sclk_2x),
    .reset (reset),
    .inc   (w_tx_unf),
    .clr   (clr_stats),
    .cnt   (tx_unf_cnt)
  );

  assign rx_fifo_data = r_rx_data;
  assign rx_fifo_ch   = r_rx_ch;
  assign rx_fifo_wr   = r_rx_wr;
  assign rx_align_err = r_align_err;

endmodule

// File: tb/tb_afe_iq_port.sv
// Bench for afe_iq_port: two instances (4 channels / 2-bit counters and
// 1 channel / 16-bit counters) share stimulus and a behavioural model.
module tb_afe_iq_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, loopback, clr_stats, rx_sel, rx_fifo_full, tx_fifo_empty;
  logic [11:0] rx_d;
  logic [23:0] tx_fifo_data;

  logic [23:0] a_rx_data, b_rx_data;
  logic [1:0]  a_rx_ch;
  logic [0:0]  b_rx_ch;
  logic        a_rx_wr, b_rx_wr, a_rd, b_rd, a_sel, b_sel, a_err, b_err;
  logic [11:0] a_txd, b_txd;
  logic [1:0]  a_ovf, a_unf;
  logic [15:0] b_ovf, b_unf;

  afe_iq_port #(.SAMPLE_WIDTH(12), .NUM_CH(4), .CNT_WIDTH(2)) u_dut_a (
    .sclk_2x(clk), .reset(reset), .enable(enable), .loopback(loopback),
    .clr_stats(clr_stats), .rx_sel(rx_sel), .rx_d(rx_d), .rx_fifo_full(rx_fifo_full),
    .rx_fifo_data(a_rx_data), .rx_fifo_ch(a_rx_ch), .rx_fifo_wr(a_rx_wr),
    .tx_fifo_empty(tx_fifo_empty), .tx_fifo_data(tx_fifo_data), .tx_fifo_rd(a_rd),
    .tx_sel(a_sel), .tx_d(a_txd), .rx_ovf_cnt(a_ovf), .tx_unf_cnt(a_unf),
    .rx_align_err(a_err)
  );

  afe_iq_port #(.SAMPLE_WIDTH(12), .NUM_CH(1), .CNT_WIDTH(16)) u_dut_b (
    .sclk_2x(clk), .reset(reset), .enable(enable), .loopback(loopback),
    .clr_stats(clr_stats), .rx_sel(rx_sel), .rx_d(rx_d), .rx_fifo_full(rx_fifo_full),
    .rx_fifo_data(b_rx_data), .rx_fifo_ch(b_rx_ch), .rx_fifo_wr(b_rx_wr),
    .tx_fifo_empty(tx_fifo_empty), .tx_fifo_data(tx_fifo_data), .tx_fifo_rd(b_rd),
    .tx_sel(b_sel), .tx_d(b_txd), .rx_ovf_cnt(b_ovf), .tx_unf_cnt(b_unf),
    .rx_align_err(b_err)
  );

  // Reference model state (index 0 = instance a, 1 = instance b)
  int nch[2]  = '{4, 1};
  int cmax[2] = '{3, 65535};
  int m_pend, m_i, m_phase, m_hv, m_hold, m_wr, m_data, m_err;
  int m_ch[2], m_chout[2], m_ovf[2], m_unf[2];
  int txq[$];
  int obs_wr[$], obs_ch[$], obs_txd[$], obs_sel[$];
  int n_rd;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational TX outputs, advance model, check registered outputs
  task automatic tick();
    int en, e_sel, e_d, e_rd, src_sel, src_d, err_set, drop, unf, was_rst;
    tx_fifo_empty = (txq.size() == 0);
    tx_fifo_data  = (txq.size() != 0) ? 24'(txq[0]) : 24'($urandom);
    #2;
    en    = (enable && !reset) ? 1 : 0;
    e_sel = en ? m_phase : 0;
    e_d   = (en && m_hv) ? (e_sel ? (m_hold & 'hFFF) : (m_hold >> 12)) : 0;
    e_rd  = (en && !m_phase && txq.size() != 0) ? 1 : 0;
    chk("tx_sel_a", 32'(a_sel), 32'(e_sel));
    chk("tx_sel_b", 32'(b_sel), 32'(e_sel));
    chk("tx_d_a",   32'(a_txd), 32'(e_d));
    chk("tx_d_b",   32'(b_txd), 32'(e_d));
    chk("tx_rd_a",  32'(a_rd),  32'(e_rd));
    chk("tx_rd_b",  32'(b_rd),  32'(e_rd));
    if (en) begin
      obs_txd.push_back(int'(a_txd));
      obs_sel.push_back(int'(a_sel));
    end
    if (a_rd) n_rd++;
    src_sel = loopback ? e_sel : int'(rx_sel);
    src_d   = loopback ? e_d   : int'(rx_d);
    err_set = 0; drop = 0; unf = 0; m_wr = 0; was_rst = reset ? 1 : 0;
    if (reset) begin
      m_pend = 0; m_i = 0; m_phase = 0; m_hv = 0; m_hold = 0; m_data = 0; m_err = 0;
      for (int k = 0; k < 2; k++) begin
        m_ch[k] = 0; m_chout[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end
    end else begin
      if (enable) begin
        if (src_sel != 0) begin
          if (m_pend != 0) err_set = 1;
          m_i = src_d; m_pend = 1;
        end else if (m_pend != 0) begin
          m_pend = 0;
          m_data = (src_d << 12) | m_i;
          for (int k = 0; k < 2; k++) begin
            m_chout[k] = m_ch[k];
            m_ch[k]    = (m_ch[k] + 1) % nch[k];
          end
          if (rx_fifo_full) drop = 1; else m_wr = 1;
        end else begin
          err_set = 1;
        end
        if (m_phase == 0) begin
          if (txq.size() != 0) begin m_hold = txq[0]; m_hv = 1; end
          else begin m_hv = 0; unf = 1; end
        end
        m_phase = 1 - m_phase;
      end else begin
        m_pend = 0; m_ch[0] = 0; m_ch[1] = 0; m_phase = 0; m_hv = 0;
      end
      for (int k = 0; k < 2; k++) begin
        if (clr_stats) begin
          m_ovf[k] = 0; m_unf[k] = 0;
        end else begin
          if (drop != 0 && m_ovf[k] < cmax[k]) m_ovf[k]++;
          if (unf  != 0 && m_unf[k] < cmax[k]) m_unf[k]++;
        end
      end
      m_err = clr_stats ? 0 : (err_set != 0 ? 1 : m_err);
    end
    if (e_rd != 0) void'(txq.pop_front());
    @(posedge clk);
    #1;
    chk("rx_wr_a", 32'(a_rx_wr), 32'(m_wr));
    chk("rx_wr_b", 32'(b_rx_wr), 32'(m_wr));
    if (m_wr != 0 || was_rst != 0) begin
      chk("rx_data_a", 32'(a_rx_data), 32'(m_data));
      chk("rx_data_b", 32'(b_rx_data), 32'(m_data));
      chk("rx_ch_a",   32'(a_rx_ch),   32'(m_chout[0]));
      chk("rx_ch_b",   32'(b_rx_ch),   32'(m_chout[1]));
    end
    chk("ovf_a", 32'(a_ovf), 32'(m_ovf[0]));
    chk("ovf_b", 32'(b_ovf), 32'(m_ovf[1]));
    chk("unf_a", 32'(a_unf), 32'(m_unf[0]));
    chk("unf_b", 32'(b_unf), 32'(m_unf[1]));
    chk("err_a", 32'(a_err), 32'(m_err));
    chk("err_b", 32'(b_err), 32'(m_err));
    if (a_rx_wr) begin
      obs_wr.push_back(int'(a_rx_data));
      obs_ch.push_back(int'(a_rx_ch));
    end
  endtask

  task automatic pair(input logic [11:0] i_val, input logic [11:0] q_val);
    rx_sel = 1'b1; rx_d = i_val; tick();
    rx_sel = 1'b0; rx_d = q_val; tick();
  endtask

  task automatic idle_clear();
    enable = 1'b0; clr_stats = 1'b1; tick(); clr_stats = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; loopback = 1'b0; clr_stats = 1'b0;
    rx_sel = 1'b0; rx_d = '0; rx_fifo_full = 1'b0;
    tx_fifo_empty = 1'b1; tx_fifo_data = '0; n_rd = 0;
    @(posedge clk); #1;
    repeat (3) tick();
    chk("rst_wr",   32'(a_rx_wr),   32'd0);
    chk("rst_data", 32'(a_rx_data), 32'd0);
    chk("rst_cnt",  32'(b_ovf),     32'd0);
    reset = 1'b0;

    // RX basic pair
    enable = 1'b1; obs_wr.delete();
    pair(12'h123, 12'h456);
    chk("basic_wr",   32'(a_rx_wr),   32'd1);
    chk("basic_data", 32'(b_rx_data), 32'h456123);
    chk("basic_ch",   32'(b_rx_ch),   32'd0);

    // Multichannel index sequence
    enable = 1'b0; tick(); enable = 1'b1;
    obs_wr.delete(); obs_ch.delete();
    repeat (5) pair(12'($urandom), 12'($urandom));
    chk("mc_count", 32'(obs_ch.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("mc_ch", 32'(obs_ch[i]), 32'(i % 4));

    // Overflow, saturation and clear-wins
    idle_clear();
    enable = 1'b1; rx_fifo_full = 1'b1; obs_wr.delete();
    repeat (3) pair(12'($urandom), 12'($urandom));
    chk("ovf_nowr", 32'(obs_wr.size()), 32'd0);
    chk("ovf3_b",   32'(b_ovf),         32'd3);
    repeat (2) pair(12'($urandom), 12'($urandom));
    chk("ovf_sat_a", 32'(a_ovf), 32'd3);
    chk("ovf5_b",    32'(b_ovf), 32'd5);
    rx_sel = 1'b1; tick();
    rx_sel = 1'b0; clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    chk("ovf_clr_a", 32'(a_ovf), 32'd0);
    chk("ovf_clr_b", 32'(b_ovf), 32'd0);
    rx_fifo_full = 1'b0;

    // Alignment: Q, I, I, Q
    idle_clear();
    enable = 1'b1; obs_wr.delete();
    rx_sel = 1'b0; rx_d = 12'h111; tick();
    rx_sel = 1'b1; rx_d = 12'h222; tick();
    rx_sel = 1'b1; rx_d = 12'h333; tick();
    rx_sel = 1'b0; rx_d = 12'h444; tick();
    chk("align_err",  32'(a_err),         32'd1);
    chk("align_nwr",  32'(obs_wr.size()), 32'd1);
    chk("align_data", 32'(obs_wr[0]),     32'h444333);
    enable = 1'b0; repeat (3) tick();
    chk("align_sticky", 32'(b_err), 32'd1);
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    chk("align_clr", 32'(a_err), 32'd0);

    // TX stream then underflow
    idle_clear();
    txq.push_back('hBBBAAA); txq.push_back('hDDDCCC);
    enable = 1'b1; rx_sel = 1'b1; obs_txd.delete(); obs_sel.delete(); n_rd = 0;
    repeat (8) tick();
    chk("tx_d1", 32'(obs_txd[1]), 32'hAAA);
    chk("tx_d2", 32'(obs_txd[2]), 32'hBBB);
    chk("tx_d3", 32'(obs_txd[3]), 32'hCCC);
    chk("tx_d4", 32'(obs_txd[4]), 32'hDDD);
    chk("tx_d5", 32'(obs_txd[5]), 32'd0);
    chk("tx_sel1", 32'(obs_sel[1]), 32'd1);
    chk("tx_sel2", 32'(obs_sel[2]), 32'd0);
    chk("tx_nrd",  32'(n_rd),       32'd2);
    chk("tx_unf",  32'(b_unf),      32'd2);

    // Loopback of the same stream into RX
    idle_clear();
    txq.push_back('hBBBAAA); txq.push_back('hDDDCCC);
    loopback = 1'b1; enable = 1'b1; obs_wr.delete();
    repeat (8) tick();
    chk("lb_wr0", 32'(obs_wr[0]), 32'hBBBAAA);
    chk("lb_wr1", 32'(obs_wr[1]), 32'hDDDCCC);
    loopback = 1'b0;

    // Reset mid-pair
    enable = 1'b0; tick(); enable = 1'b1; obs_wr.delete();
    rx_sel = 1'b1; rx_d = 12'h5A5; tick();
    reset = 1'b1; rx_sel = 1'b0; rx_d = 12'hA5A; tick();
    chk("mrst_wr",   32'(a_rx_wr),   32'd0);
    chk("mrst_data", 32'(a_rx_data), 32'd0);
    chk("mrst_unf",  32'(b_unf),     32'd0);
    chk("mrst_sel",  32'(a_sel),     32'd0);
    chk("mrst_txd",  32'(a_txd),     32'd0);
    reset = 1'b0; tick();
    chk("mrst_nowr", 32'(obs_wr.size()), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      enable       = ($urandom % 16) != 0;
      loopback     = ($urandom % 4) == 0;
      rx_sel       = (($urandom % 8) == 0) ? 1'($urandom) : ~rx_sel;
      rx_d         = 12'($urandom);
      rx_fifo_full = ($urandom % 4) == 0;
      clr_stats    = ($urandom % 32) == 0;
      reset        = ($urandom % 128) == 0;
      if (($urandom % 2) == 0 && txq.size() < 4) txq.push_back(int'(24'($urandom)));
      tick();
    end
    reset = 1'b0; clr_stats = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
